// File: rtl/computer_top_pkg.sv
// Shared definitions for the computer board I/O shell: VGA 640x480 timing,
// the button bundle type and the hex-to-segment table.
package computer_top_pkg;

    localparam logic [9:0] H_VISIBLE = 10'd640;
    localparam logic [9:0] H_FRONT   = 10'd16;
    localparam logic [9:0] H_SYNC    = 10'd96;
    localparam logic [9:0] H_TOTAL   = 10'd800;
    localparam logic [9:0] V_VISIBLE = 10'd480;
    localparam logic [9:0] V_FRONT   = 10'd10;
    localparam logic [9:0] V_SYNC    = 10'd2;
    localparam logic [9:0] V_TOTAL   = 10'd525;

    localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

    typedef struct packed {
        logic center;
        logic up;
        logic down;
        logic left;
        logic right;
    } btn_t;

    // Active-high segments {g,f,e,d,c,b,a}; the top inverts for the board.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/computer_top_buttons.sv
// Five debounced push-buttons with registered single-clock rising-edge pulses.
module computer_top_buttons
    import computer_top_pkg::*;
#(
    parameter int DB_WIDTH = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic button_up,
    input  logic button_down,
    input  logic button_left,
    input  logic button_right,
    input  logic button_center,
    output btn_t pulse
);

    btn_t level;
    btn_t armed;
    btn_t prev;

    debounce #(.WIDTH(DB_WIDTH)) _db_up (
        .clk(clk), .reset(reset), .raw(button_up),
        .level(level.up), .armed(armed.up)
    );
    debounce #(.WIDTH(DB_WIDTH)) _db_left (
        .clk(clk), .reset(reset), .raw(button_left),
        .level(level.left), .armed(armed.left)
    );
    debounce #(.WIDTH(DB_WIDTH)) _db_center (
        .clk(clk), .reset(reset), .raw(button_center),
        .level(level.center), .armed(armed.center)
    );
    debounce #(.WIDTH(DB_WIDTH)) _db_right (
        .clk(clk), .reset(reset), .raw(button_right),
        .level(level.right), .armed(armed.right)
    );
    debounce #(.WIDTH(DB_WIDTH)) _db_down (
        .clk(clk), .reset(reset), .raw(button_down),
        .level(level.down), .armed(armed.down)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev  <= '0;
            pulse <= '0;
        end else begin
            prev  <= level;
            pulse <= level & ~prev & armed;
        end
    end

endmodule

// File: rtl/debounce.sv
// One push-button path: 2-flop synchronizer, saturating-counter debouncer,
// and an arm flag that stays low until the button is seen released after reset.
module debounce #(
    parameter int WIDTH = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic armed
);

    logic [1:0]       sync_ff;
    logic [1:0]       valid_ff;
    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_ff  <= '0;
            valid_ff <= '0;
            cnt      <= '0;
            level    <= 1'b0;
            armed    <= 1'b0;
        end else begin
            sync_ff  <= {sync_ff[0], raw};
            valid_ff <= {valid_ff[0], 1'b1};
            // A press held through reset must not count until it is released.
            if (valid_ff[1] && !sync_ff[1])
                armed <= 1'b1;
            if (sync_ff[1] == level)
                cnt <= '0;
            else if (cnt == '1) begin
                level <= sync_ff[1];
                cnt   <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/computer_top.sv
// Board I/O shell: button-edited 16-bit register shown on LEDs, a scanned
// 4-digit 7-segment display and as the colour of a 640x480 VGA raster.
module computer_top
    import computer_top_pkg::*;
#(
    parameter int DB_WIDTH     = 16,
    parameter int REFRESH_BITS = 16
) (
    input  logic       ext_clk,
    input  logic       reset,
    input  logic       enable,
    inout  tri         sensor_data,
    input  logic       button_up,
    input  logic       button_down,
    input  logic       button_left,
    input  logic       button_right,
    input  logic       button_center,
    input  logic [5:0] switches,
    output logic [7:0] color,
    output logic       HSync,
    output logic       VSync,
    output logic [7:0] led_out,
    output logic [3:0] an,
    output logic [7:0] seg
);

    assign sensor_data = 1'bz;

    btn_t        pulse;
    logic [15:0] count;

    computer_top_buttons #(.DB_WIDTH(DB_WIDTH)) _buttons (
        .clk          (ext_clk),
        .reset        (reset),
        .button_up    (button_up),
        .button_down  (button_down),
        .button_left  (button_left),
        .button_right (button_right),
        .button_center(button_center),
        .pulse        (pulse)
    );

    always_ff @(posedge ext_clk) begin
        if (!reset) begin
            count   <= '0;
            led_out <= '0;
        end else begin
            if (enable) begin
                if (pulse.center)
                    count <= {10'b0, switches};
                else if (pulse.up)
                    count <= count + 16'd1;
                else if (pulse.down)
                    count <= count - 16'd1;
                else if (pulse.left)
                    count <= count << 1;
                else if (pulse.right)
                    count <= count >> 1;
            end
            led_out <= count[7:0];
        end
    end

    logic [REFRESH_BITS+1:0] refresh;
    logic [1:0]              digit;
    logic [3:0]              nibble;

    assign digit = refresh[REFRESH_BITS +: 2];

    always_comb begin
        nibble = count[3:0];
        case (digit)
            2'd0: nibble = count[3:0];
            2'd1: nibble = count[7:4];
            2'd2: nibble = count[11:8];
            2'd3: nibble = count[15:12];
            default: nibble = count[3:0];
        endcase
    end

    always_ff @(posedge ext_clk) begin
        if (!reset) begin
            refresh <= '0;
            an      <= 4'b1111;
            seg     <= 8'hFF;
        end else begin
            refresh <= refresh + 1'b1;
            an      <= ~(4'b0001 << digit);
            seg     <= {1'b1, ~hex_to_seg(nibble)};
        end
    end

    logic [1:0] pix_div;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;

    always_ff @(posedge ext_clk) begin
        if (!reset) begin
            pix_div <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
            HSync   <= 1'b1;
            VSync   <= 1'b1;
            color   <= '0;
        end else begin
            pix_div <= pix_div + 2'd1;
            if (pix_div == 2'd3) begin
                if (h_cnt == H_TOTAL - 10'd1) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_TOTAL - 10'd1) ? 10'd0 : v_cnt + 10'd1;
                end else
                    h_cnt <= h_cnt + 10'd1;
            end
            HSync <= !(h_cnt >= H_SYNC_START && h_cnt < H_SYNC_END);
            VSync <= !(v_cnt >= V_SYNC_START && v_cnt < V_SYNC_END);
            color <= (h_cnt < H_VISIBLE && v_cnt < V_VISIBLE) ? count[7:0] : 8'h00;
        end
    end

endmodule

// File: tb/tb_computer_top.sv
// Directed bench for computer_top with short debounce and refresh periods.
module tb_computer_top;

    logic       ext_clk = 1'b0;
    logic       reset   = 1'b0;
    logic       enable  = 1'b0;
    logic [4:0] btn     = 5'b0;
    logic [5:0] switches = 6'h00;
    tri         sensor_data;
    logic [7:0] color;
    logic       HSync;
    logic       VSync;
    logic [7:0] led_out;
    logic [3:0] an;
    logic [7:0] seg;

    localparam logic [4:0] B_C = 5'b10000;
    localparam logic [4:0] B_U = 5'b01000;
    localparam logic [4:0] B_D = 5'b00100;
    localparam logic [4:0] B_L = 5'b00010;
    localparam logic [4:0] B_R = 5'b00001;

    computer_top #(.DB_WIDTH(1), .REFRESH_BITS(2)) dut (
        .ext_clk      (ext_clk),
        .reset        (reset),
        .enable       (enable),
        .sensor_data  (sensor_data),
        .button_up    (btn[3]),
        .button_down  (btn[2]),
        .button_left  (btn[1]),
        .button_right (btn[0]),
        .button_center(btn[4]),
        .switches     (switches),
        .color        (color),
        .HSync        (HSync),
        .VSync        (VSync),
        .led_out      (led_out),
        .an           (an),
        .seg          (seg)
    );

    always #5 ext_clk = ~ext_clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge ext_clk);
    endtask

    task automatic press(input logic [4:0] mask, input int n);
        for (int i = 0; i < n; i++) begin
            btn = mask;
            clocks(8);
            btn = 5'b0;
            clocks(8);
        end
    endtask

    logic [3:0] an_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] seg_exp[4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};

    initial begin
        int waited;
        int hs_low, vs_low, col_vis, col_blank;

        clocks(5);
        check("rst_count", dut.count, 32'h0);
        check("rst_led", led_out, 32'h0);
        check("rst_an", an, 32'hF);
        check("rst_seg", seg, 32'hFF);
        check("rst_hsync", HSync, 32'h1);
        check("rst_vsync", VSync, 32'h1);
        check("rst_color", color, 32'h0);

        reset  = 1'b1;
        enable = 1'b1;
        clocks(1);
        check("first_an", an, 32'hE);
        clocks(4);

        btn = B_U;
        clocks(5);
        check("up_lat5", dut.count, 32'h0);
        clocks(1);
        check("up_lat6", dut.count, 32'h1);
        clocks(14);
        check("up_held", dut.count, 32'h1);
        check("up_led", led_out, 32'h01);
        btn = 5'b0;
        clocks(10);
        press(B_U, 1);
        check("up_again", dut.count, 32'h2);

        press(B_C, 1);
        check("center_zero", dut.count, 32'h0);
        press(B_D, 1);
        check("down_wrap", dut.count, 32'hFFFF);
        check("down_led", led_out, 32'hFF);
        press(B_U, 1);
        check("up_wrap", dut.count, 32'h0);

        switches = 6'h2A;
        press(B_C | B_U, 1);
        check("center_prio", dut.count, 32'h2A);
        press(B_L, 1);
        check("left", dut.count, 32'h54);
        press(B_R, 1);
        check("right", dut.count, 32'h2A);

        enable = 1'b0;
        btn = B_U;
        clocks(10);
        check("en0_hold", dut.count, 32'h2A);
        enable = 1'b1;
        clocks(10);
        check("en1_still_held", dut.count, 32'h2A);
        btn = 5'b0;
        clocks(10);
        check("en1_release", dut.count, 32'h2A);
        press(B_U, 1);
        check("en1_repress", dut.count, 32'h2B);

        btn = B_U;
        clocks(1);
        btn = 5'b0;
        clocks(10);
        check("glitch", dut.count, 32'h2B);

        btn = B_U;
        clocks(3);
        reset = 1'b0;
        clocks(3);
        reset = 1'b1;
        clocks(20);
        check("rst_midpress", dut.count, 32'h0);
        btn = 5'b0;
        clocks(10);
        press(B_U, 1);
        check("rst_repress", dut.count, 32'h1);

        switches = 6'h24;
        press(B_C, 1);
        press(B_L, 4);
        press(B_U, 6);
        check("build_246", dut.count, 32'h246);
        press(B_L, 3);
        press(B_U, 4);
        check("build_1234", dut.count, 32'h1234);
        check("led_34", led_out, 32'h34);

        waited = 0;
        while (an != 4'b0111 && waited < 20) begin
            clocks(1);
            waited++;
        end
        check("scan_find_d3", an, 32'h7);
        waited = 0;
        while (an != 4'b1110 && waited < 8) begin
            clocks(1);
            waited++;
        end
        check("scan_find_d0", an, 32'hE);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                check($sformatf("scan_an_d%0d_c%0d", d, c), an, an_exp[d]);
                check($sformatf("scan_seg_d%0d_c%0d", d, c), seg, seg_exp[d]);
                clocks(1);
            end
        end

        hs_low = 0; vs_low = 0; col_vis = 0; col_blank = 0;
        for (int i = 0; i < 3200; i++) begin
            if (HSync == 1'b0) hs_low++;
            if (VSync == 1'b0) vs_low++;
            if (color == 8'h34) col_vis++;
            if (color == 8'h00) col_blank++;
            clocks(1);
        end
        check("hsync_low_clocks", hs_low, 32'd384);
        check("vsync_low_in_line", vs_low, 32'd0);
        check("color_visible", col_vis, 32'd2560);
        check("color_blank", col_blank, 32'd640);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
